// File: rtl/wb_master_if.sv
// Request/response port of the J1 I/O bridge plus the Wishbone classic bus it drives.
// Signal names match the bridge's established port list.
interface wb_master_if #(
  parameter int AW = 16,
  parameter int DW = 16
);
  logic          req_i;
  logic          req_we_i;
  logic [AW-1:0] req_adr_i;
  logic [DW-1:0] req_dat_i;
  logic          busy_o;
  logic          rsp_valid_o;
  logic          rsp_err_o;
  logic [DW-1:0] rsp_dat_o;
  logic          wb_cyc_o;
  logic          wb_stb_o;
  logic          wb_we_o;
  logic [AW-1:0] wb_adr_o;
  logic [DW-1:0] wb_dat_o;
  logic [DW-1:0] wb_dat_i;
  logic          wb_ack_i;

  modport master (
    input  req_i, req_we_i, req_adr_i, req_dat_i, wb_dat_i, wb_ack_i,
    output busy_o, rsp_valid_o, rsp_err_o, rsp_dat_o,
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o
  );

  modport slave (
    output req_i, req_we_i, req_adr_i, req_dat_i, wb_dat_i, wb_ack_i,
    input  busy_o, rsp_valid_o, rsp_err_o, rsp_dat_o,
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o
  );
endinterface

// File: rtl/wb_master.sv
// Wishbone classic single-transfer master with ACK timeout.
// state  | meaning
// IDLE   | no bus cycle; accepts a request at any edge with req_i=1
// ACTIVE | CYC/STB held until ACK or timeout; new requests ignored
module wb_master #(
  parameter int AW      = 16,
  parameter int DW      = 16,
  parameter int TIMEOUT = 15
) (
  input  logic clk_i,
  input  logic rst_i,
  wb_master_if.master bus
);

  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT < 1) ? '0 : CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX  = '1;

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic          rsp_err_q, rsp_err_d;
  logic [DW-1:0] rsp_dat_q, rsp_dat_d;
  logic          cyc_q, cyc_d;
  logic          stb_q, stb_d;
  logic          we_q, we_d;
  logic [AW-1:0] adr_q, adr_d;
  logic [DW-1:0] dat_q, dat_d;

  logic ack, tmo;

  // ACK outside a cycle is stale; ACK beats a coincident timeout
  assign ack = (state_q == ACTIVE) && bus.wb_ack_i;
  assign tmo = (TIMEOUT != 0) && (state_q == ACTIVE) && !bus.wb_ack_i
               && (cnt_q == CNT_LAST);

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_dat_q   <= '0;
      cyc_q       <= 1'b0;
      stb_q       <= 1'b0;
      we_q        <= 1'b0;
      adr_q       <= '0;
      dat_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_dat_q   <= rsp_dat_d;
      cyc_q       <= cyc_d;
      stb_q       <= stb_d;
      we_q        <= we_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.req_i) state_d = ACTIVE;
      ACTIVE:  if (ack || tmo) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d       = cnt_q;
    busy_d      = busy_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_dat_d   = rsp_dat_q;
    cyc_d       = cyc_q;
    stb_d       = stb_q;
    we_d        = we_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    case (state_q)
      IDLE: begin
        if (bus.req_i) begin
          cnt_d  = '0;
          busy_d = 1'b1;
          cyc_d  = 1'b1;
          stb_d  = 1'b1;
          we_d   = bus.req_we_i;
          adr_d  = bus.req_adr_i;
          dat_d  = bus.req_we_i ? bus.req_dat_i : '0;
        end
      end
      ACTIVE: begin
        if (ack || tmo) begin
          busy_d      = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = tmo;
          cyc_d       = 1'b0;
          stb_d       = 1'b0;
          we_d        = 1'b0;
          adr_d       = '0;
          dat_d       = '0;
          if (!we_q) rsp_dat_d = ack ? bus.wb_dat_i : '0;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: ;
    endcase
  end

  assign bus.busy_o      = busy_q;
  assign bus.rsp_valid_o = rsp_valid_q;
  assign bus.rsp_err_o   = rsp_err_q;
  assign bus.rsp_dat_o   = rsp_dat_q;
  assign bus.wb_cyc_o    = cyc_q;
  assign bus.wb_stb_o    = stb_q;
  assign bus.wb_we_o     = we_q;
  assign bus.wb_adr_o    = adr_q;
  assign bus.wb_dat_o    = dat_q;

endmodule
